// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared types, constants and CRC-32 byte update for the Ethernet TX path.
`timescale 1ns/1ps
`default_nettype none
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_IFG      = 3'd6
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  // Reflected CRC-32, one byte per call, LSB of the data byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_crc32.sv
// eth_crc32: byte-wide CRC-32 accumulator with synchronous clear.
`timescale 1ns/1ps
`default_nettype none
module eth_crc32
  import eth_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (enable) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rmii_frame_tx.sv
// rmii_frame_tx: byte stream to RMII/MII frame (preamble, SFD, pad, FCS, IFG).
`timescale 1ns/1ps
`default_nettype none
module rmii_frame_tx
  import eth_tx_pkg::*;
#(
  parameter int TXD_W          = 2,
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_PAYLOAD    = 60,
  parameter int FCS_EN         = 1,
  parameter int IFG_BYTES      = 12
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [TXD_W-1:0] tx_d,
  output logic             tx_e,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o
);

  localparam int               SPB      = 8 / TXD_W;
  localparam int               SYM_W    = (SPB > 1) ? $clog2(SPB) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SPB - 1);
  localparam logic [7:0]       PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]       IFG_LAST = 8'(IFG_BYTES - 1);
  localparam logic [10:0]      MIN_CNT  = 11'(MIN_PAYLOAD);

  tx_state_t        state;
  logic [SYM_W-1:0] sym_cnt;
  logic [7:0]       byte_cnt;
  logic [7:0]       shreg;
  logic [10:0]      count;
  logic [10:0]      count_inc;
  logic             last_flag;
  logic [31:0]      crc;
  logic [31:0]      fcs;
  logic [7:0]       nxt_byte;
  logic             last_sym;
  logic             accept;
  logic             start;
  logic             pad_byte;

  assign last_sym  = (sym_cnt == SYM_LAST);
  assign s_ready   = last_sym && ((state == ST_SFD) || (state == ST_DATA && !last_flag));
  assign accept    = s_ready && s_valid;
  // A waiting frame leaves IFG directly into PREAMBLE so back-to-back frames lose no cycle.
  assign start     = s_valid && ((state == ST_IDLE) ||
                     (state == ST_IFG && last_sym && byte_cnt == IFG_LAST));
  assign pad_byte  = last_sym && (count < MIN_CNT) &&
                     ((state == ST_PAD) || (state == ST_DATA && last_flag));
  assign count_inc = (count == 11'h7FF) ? count : count + 11'd1;
  assign fcs       = ~crc;

  eth_crc32 u_crc (
    .clk    (ref_clk),
    .rst_n  (rst_n),
    .clear  (start),
    .enable (accept || pad_byte),
    .data   (accept ? s_data : 8'h00),
    .crc    (crc)
  );

  always_comb begin
    nxt_byte = 8'h00;
    case (state)
      ST_IDLE, ST_IFG:         nxt_byte = PREAMBLE_BYTE;
      ST_PREAMBLE:             nxt_byte = (byte_cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
      ST_SFD, ST_DATA, ST_PAD: nxt_byte = accept ? s_data : (pad_byte ? 8'h00 : fcs[7:0]);
      ST_FCS: begin
        case (byte_cnt[1:0])
          2'd0:    nxt_byte = fcs[15:8];
          2'd1:    nxt_byte = fcs[23:16];
          2'd2:    nxt_byte = fcs[31:24];
          default: nxt_byte = 8'h00;
        endcase
      end
      default:                 nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sym_cnt    <= '0;
      byte_cnt   <= 8'h00;
      shreg      <= 8'h00;
      count      <= 11'd0;
      last_flag  <= 1'b0;
      tx_d       <= '0;
      tx_e       <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      done_o     <= 1'b0;
      underrun_o <= 1'b0;
      if (start) begin
        state     <= ST_PREAMBLE;
        sym_cnt   <= '0;
        byte_cnt  <= 8'h00;
        count     <= 11'd0;
        last_flag <= 1'b0;
        tx_e      <= 1'b1;
        busy_o    <= 1'b1;
        tx_d      <= nxt_byte[TXD_W-1:0];
        shreg     <= nxt_byte >> TXD_W;
      end else if (state != ST_IDLE && !last_sym) begin
        sym_cnt <= sym_cnt + 1'b1;
        tx_d    <= shreg[TXD_W-1:0];
        shreg   <= shreg >> TXD_W;
      end else if (state != ST_IDLE) begin
        sym_cnt <= '0;
        case (state)
          ST_PREAMBLE: begin
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == PRE_LAST) state <= ST_SFD;
            tx_d  <= nxt_byte[TXD_W-1:0];
            shreg <= nxt_byte >> TXD_W;
          end
          ST_SFD, ST_DATA, ST_PAD: begin
            if (accept) begin
              state     <= ST_DATA;
              count     <= count_inc;
              last_flag <= s_last;
              tx_d      <= nxt_byte[TXD_W-1:0];
              shreg     <= nxt_byte >> TXD_W;
            end else if (pad_byte) begin
              state <= ST_PAD;
              count <= count_inc;
              tx_d  <= nxt_byte[TXD_W-1:0];
              shreg <= nxt_byte >> TXD_W;
            end else if (state == ST_SFD || (state == ST_DATA && !last_flag)) begin
              state      <= ST_IFG;
              byte_cnt   <= 8'h00;
              tx_e       <= 1'b0;
              tx_d       <= '0;
              shreg      <= 8'h00;
              underrun_o <= 1'b1;
            end else if (FCS_EN != 0) begin
              state    <= ST_FCS;
              byte_cnt <= 8'h00;
              tx_d     <= nxt_byte[TXD_W-1:0];
              shreg    <= nxt_byte >> TXD_W;
            end else begin
              state    <= ST_IFG;
              byte_cnt <= 8'h00;
              tx_e     <= 1'b0;
              tx_d     <= '0;
              shreg    <= 8'h00;
              done_o   <= 1'b1;
            end
          end
          ST_FCS: begin
            if (byte_cnt == 8'd3) begin
              state    <= ST_IFG;
              byte_cnt <= 8'h00;
              tx_e     <= 1'b0;
              tx_d     <= '0;
              shreg    <= 8'h00;
              done_o   <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
              tx_d     <= nxt_byte[TXD_W-1:0];
              shreg    <= nxt_byte >> TXD_W;
            end
          end
          ST_IFG: begin
            if (byte_cnt == IFG_LAST) begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end else begin
              byte_cnt <= byte_cnt + 8'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rmii_frame_tx.sv
// tb_rmii_frame_tx: directed checks of an RMII instance (defaults) and an MII instance without padding.
`timescale 1ns/1ps
`default_nettype none
module tb_rmii_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, a_last, b_valid, b_last;
  logic       a_ready, b_ready;
  logic [1:0] a_txd;
  logic [3:0] b_txd;
  logic       a_txe, b_txe, a_busy, b_busy, a_done, b_done, a_und, b_und;

  rmii_frame_tx dut_a (
    .ref_clk(clk), .rst_n(rst_n), .s_data(a_data), .s_valid(a_valid), .s_last(a_last),
    .s_ready(a_ready), .tx_d(a_txd), .tx_e(a_txe), .busy_o(a_busy), .done_o(a_done),
    .underrun_o(a_und)
  );

  rmii_frame_tx #(.TXD_W(4), .MIN_PAYLOAD(0)) dut_b (
    .ref_clk(clk), .rst_n(rst_n), .s_data(b_data), .s_valid(b_valid), .s_last(b_last),
    .s_ready(b_ready), .tx_d(b_txd), .tx_e(b_txe), .busy_o(b_busy), .done_o(b_done),
    .underrun_o(b_und)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc++;

  logic [7:0] pay [64];
  logic [7:0] exp_q [$];
  logic [7:0] a_q [$];
  logic [3:0] b_nq [$];
  logic [7:0] a_sh = 8'h00;
  int a_sc = 0, a_high = 0, a_dones = 0, a_unds = 0, a_efall = 0, a_bfall = 0;
  int b_high = 0, b_dones = 0;
  logic a_pe = 1'b0, a_pb = 1'b0;

  // Wire monitors: rebuild bytes (A) and nibbles (B) while tx_e is high.
  always @(negedge clk) begin
    if (a_txe) begin
      a_high++;
      a_sh = {a_txd, a_sh[7:2]};
      a_sc++;
      if (a_sc == 4) begin
        a_q.push_back(a_sh);
        a_sc = 0;
      end
    end else begin
      a_sc = 0;
    end
    if (a_done) a_dones++;
    if (a_und) a_unds++;
    if (a_pe && !a_txe) a_efall = cyc;
    if (a_pb && !a_busy) a_bfall = cyc;
    a_pe = a_txe;
    a_pb = a_busy;
    if (b_txe) begin
      b_high++;
      b_nq.push_back(b_txd);
    end
    if (b_done) b_dones++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    a_q.delete(); b_nq.delete();
    a_high = 0; a_dones = 0; a_unds = 0; a_efall = 0; a_bfall = 0;
    b_high = 0; b_dones = 0;
  endtask

  // Expected frame for instance A: preamble, SFD, payload, zero pad, ~CRC low byte first.
  task automatic build_exp(input int n, input int minp);
    logic [31:0] c;
    logic [7:0]  d;
    logic        fb;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < ((n > minp) ? n : minp); i++) begin
      d = (i < n) ? pay[i] : 8'h00;
      exp_q.push_back(d);
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
  endtask

  task automatic cmp_frame(input string tag);
    check({tag, "_len"}, a_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < a_q.size(); i++)
      check($sformatf("%s_b%0d", tag, i), a_q[i], exp_q[i]);
  endtask

  task automatic send(input bit sel, input int n, input bit use_last);
    int   i = 0;
    int   guard = 0;
    logic rdy;
    @(posedge clk); #1;
    if (!sel) begin a_data = pay[0]; a_last = use_last && (n == 1); a_valid = 1'b1; end
    else      begin b_data = pay[0]; b_last = use_last && (n == 1); b_valid = 1'b1; end
    @(negedge clk); @(negedge clk);
    if (!sel) check("a_start", {a_txe, a_busy, a_txd}, 4'b1101);
    else      check("b_start", {b_txe, b_busy, b_txd}, 6'b110101);
    while (i < n && guard < 3000) begin
      @(negedge clk);
      guard++;
      rdy = sel ? b_ready : a_ready;
      if (rdy) begin
        @(posedge clk); #1;
        i++;
        if (i < n) begin
          if (!sel) begin a_data = pay[i]; a_last = use_last && (i == n - 1); end
          else      begin b_data = pay[i]; b_last = use_last && (i == n - 1); end
        end
      end
    end
    if (!sel) begin a_valid = 1'b0; a_last = 1'b0; end
    else      begin b_valid = 1'b0; b_last = 1'b0; end
    check("send_accepted", i, n);
  endtask

  task automatic wait_idle(input bit sel);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((sel ? b_busy : a_busy) && k < 2000);
    check(sel ? "b_idle" : "a_idle", sel ? b_busy : a_busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_data = 8'h00; a_valid = 1'b0; a_last = 1'b0;
    b_data = 8'h00; b_valid = 1'b0; b_last = 1'b0;
    repeat (3) @(negedge clk);
    check("a_reset", {a_txe, a_txd, a_ready, a_busy, a_done, a_und}, 7'd0);
    check("b_reset", {b_txe, b_txd, b_ready, b_busy, b_done, b_und}, 9'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 60-byte payload: no padding, exact frame length, FCS and IFG timing.
    clr();
    for (int i = 0; i < 60; i++) pay[i] = 8'(i);
    send(1'b0, 60, 1'b1);
    wait_idle(1'b0);
    build_exp(60, 60);
    cmp_frame("t60");
    check("t60_txe_cycles", a_high, 288);
    check("t60_done", a_dones, 1);
    check("t60_underrun", a_unds, 0);
    check("t60_ifg", a_bfall - a_efall, 48);

    // Single byte: 59 pad bytes then FCS.
    clr();
    pay[0] = 8'hAB;
    send(1'b0, 1, 1'b1);
    wait_idle(1'b0);
    build_exp(1, 60);
    cmp_frame("t1");
    check("t1_txe_cycles", a_high, 288);
    check("t1_done", a_dones, 1);

    // Underrun after ten payload bytes.
    clr();
    for (int i = 0; i < 10; i++) pay[i] = 8'hC0 + 8'(i);
    send(1'b0, 10, 1'b0);
    wait_idle(1'b0);
    check("und_txe_cycles", a_high, 72);
    check("und_pulse", a_unds, 1);
    check("und_no_done", a_dones, 0);
    check("und_ifg", a_bfall - a_efall, 48);
    check("und_bytes", a_q.size(), 18);
    if (a_q.size() == 18) check("und_last_byte", a_q[17], 8'hC9);

    // Asynchronous reset in the middle of DATA, then a clean frame.
    clr();
    for (int i = 0; i < 5; i++) pay[i] = 8'h10 + 8'(i);
    send(1'b0, 5, 1'b0);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_outputs", {a_txe, a_ready, a_busy, a_done, a_und}, 5'd0);
    @(negedge clk);
    check("rst_mid_no_pulse", a_unds + a_dones, 0);
    rst_n = 1'b1;
    @(negedge clk);
    clr();
    pay[0] = 8'hDE; pay[1] = 8'hAD; pay[2] = 8'hBE;
    send(1'b0, 3, 1'b1);
    wait_idle(1'b0);
    build_exp(3, 60);
    cmp_frame("post_rst");
    check("post_rst_txe_cycles", a_high, 288);

    // MII, no padding: "123456789" must carry FCS 26 39 F4 CB.
    clr();
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    send(1'b1, 9, 1'b1);
    wait_idle(1'b1);
    check("mii_txe_cycles", b_high, 42);
    check("mii_done", b_dones, 1);
    check("mii_nibbles", b_nq.size(), 42);
    if (b_nq.size() == 42) begin
      for (int k = 0; k < 15; k++) check($sformatf("mii_pre_n%0d", k), b_nq[k], 4'h5);
      check("mii_sfd_hi", b_nq[15], 4'hD);
      check("mii_first_data", {b_nq[17], b_nq[16]}, 8'h31);
      check("mii_fcs0", {b_nq[35], b_nq[34]}, 8'h26);
      check("mii_fcs1", {b_nq[37], b_nq[36]}, 8'h39);
      check("mii_fcs2", {b_nq[39], b_nq[38]}, 8'hF4);
      check("mii_fcs3", {b_nq[41], b_nq[40]}, 8'hCB);
    end

    // MII nibble order of 0xA5: low nibble first.
    clr();
    pay[0] = 8'hA5;
    send(1'b1, 1, 1'b1);
    wait_idle(1'b1);
    check("mii_a5_cycles", b_high, 26);
    if (b_nq.size() >= 18) begin
      check("mii_a5_lo", b_nq[16], 4'h5);
      check("mii_a5_hi", b_nq[17], 4'hA);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
